// File: rtl/apb_uart_master.sv
// apb_uart_master: APB initiator that converts single host register commands
// (valid/ready) into APB SETUP/ACCESS transfers, bounds each PREADY wait with a
// timeout, and returns read data and error status on a backpressured response port.
module apb_uart_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK_i,
    input  logic                  PRESETn_i,
    // host command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    // host response port
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    // APB initiator
    output logic                  PSEL_o,
    output logic                  PENABLE_o,
    output logic                  PWRITE_o,
    output logic [ADDR_WIDTH-1:0] PADDR_o,
    output logic [DATA_WIDTH-1:0] PWDATA_o,
    input  logic [DATA_WIDTH-1:0] PRDATA_i,
    input  logic                  PREADY_i,
    input  logic                  PSLVERR_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Wait-counter value seen in the last ACCESS cycle allowed before abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  psel_reg, psel_next;
    logic                  penable_reg, penable_next;
    logic                  pwrite_reg, pwrite_next;
    logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;

    // State and output registers; reset discards any in-flight transfer or response.
    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            cmd_ready_reg   <= 1'b0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cmd_ready_reg   <= cmd_ready_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Next-state and next-output logic; every register holds unless its state updates it.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cmd_ready_next   = cmd_ready_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            IDLE: begin
                // cmd_ready is registered, so the first IDLE cycle after reset
                // only raises it; acceptance needs the handshake to be visible.
                cmd_ready_next = 1'b1;
                if (cmd_valid_i && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    pwrite_next    = cmd_write_i;
                    paddr_next     = cmd_addr_i;
                    pwdata_next    = cmd_wdata_i;
                    psel_next      = 1'b1;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                cnt_next     = '0;
                state_next   = ACCESS;
            end
            ACCESS: begin
                // Completion wins over timeout when both land in the same cycle.
                if (PREADY_i) begin
                    rsp_rdata_next   = pwrite_reg ? '0 : PRDATA_i;
                    rsp_err_next     = PSLVERR_i;
                    rsp_timeout_next = 1'b0;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = cmd_ready_reg;
    assign PSEL_o        = psel_reg;
    assign PENABLE_o     = penable_reg;
    assign PWRITE_o      = pwrite_reg;
    assign PADDR_o       = paddr_reg;
    assign PWDATA_o      = pwdata_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_rdata_o   = rsp_rdata_reg;
    assign rsp_err_o     = rsp_err_reg;
    assign rsp_timeout_o = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: directed, cycle-accurate checks of apb_uart_master with a
// response scoreboard; the bench plays the APB slave directly.
module tb_apb_uart_master;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          timeout;
    } rsp_t;

    rsp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    apb_uart_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK_i       (clk),
        .PRESETn_i    (rstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .PSEL_o       (psel),
        .PENABLE_o    (penable),
        .PWRITE_o     (pwrite),
        .PADDR_o      (paddr),
        .PWDATA_o     (pwdata),
        .PRDATA_i     (prdata),
        .PREADY_i     (pready),
        .PSLVERR_i    (pslverr)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic exp_ready);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(exp_ready));
        chk({tag, "_psel"}, 32'(psel), 32'd0);
        chk({tag, "_penable"}, 32'(penable), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // One full command/response transaction. ready_k = ACCESS cycle with PREADY (0 = never).
    task automatic xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int ready_k, input logic [DW-1:0] rd,
                        input logic slverr, input int hold_cycles, input logic hold_valid);
        rsp_t e;
        rsp_t got;
        int   cyc;
        cyc = 0;
        chk({name, "_c0_cmd_ready"}, 32'(cmd_ready), 32'd1);
        e.rdata   = (ready_k != 0 && !wr) ? rd : '0;
        e.err     = (ready_k != 0) ? slverr : 1'b1;
        e.timeout = (ready_k == 0);
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cyc++;
        if (!hold_valid) cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_write = ~wr;
        chk({name, "_setup_psel"}, 32'(psel), 32'd1);
        chk({name, "_setup_penable"}, 32'(penable), 32'd0);
        chk({name, "_setup_paddr"}, 32'(paddr), 32'(addr));
        chk({name, "_setup_pwdata"}, 32'(pwdata), 32'(wd));
        chk({name, "_setup_pwrite"}, 32'(pwrite), 32'(wr));
        chk({name, "_setup_cmd_ready"}, 32'(cmd_ready), 32'd0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            cyc++;
            chk({name, "_access_psel"}, 32'(psel), 32'd1);
            chk({name, "_access_penable"}, 32'(penable), 32'd1);
            chk({name, "_access_paddr"}, 32'(paddr), 32'(addr));
            chk({name, "_access_pwdata"}, 32'(pwdata), 32'(wd));
            chk({name, "_access_pwrite"}, 32'(pwrite), 32'(wr));
            chk({name, "_access_rsp_valid"}, 32'(rsp_valid), 32'd0);
            chk({name, "_access_cmd_ready"}, 32'(cmd_ready), 32'd0);
            pready  = (k == ready_k);
            prdata  = pready ? rd : DW'($urandom);
            pslverr = pready ? slverr : 1'($urandom);
            if (k == ready_k) break;
        end
        tick();
        cyc++;
        pready  = 1'b0;
        prdata  = DW'($urandom);
        pslverr = 1'b1;
        chk({name, "_rsp_valid_rise"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rsp_psel_drop"}, 32'(psel), 32'd0);
        chk({name, "_rsp_penable_drop"}, 32'(penable), 32'd0);
        chk({name, "_rsp_cmd_ready"}, 32'(cmd_ready), 32'd0);
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", name);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_rsp_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
            chk({name, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
            chk({name, "_rsp_timeout"}, 32'(rsp_timeout), 32'(e.timeout));
        end
        got = '{rsp_rdata, rsp_err, rsp_timeout};
        $display("txn %s wr=%0d addr=%0h wdata=%0h rsp_cycle=%0d rdata=%0h err=%0d timeout=%0d",
                 name, wr, addr, wd, cyc, got.rdata, got.err, got.timeout);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            chk({name, "_hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, "_hold_rsp_fields"}, 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'(e));
            chk({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            chk({name, "_hold_psel"}, 32'(psel), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_idle_outputs({name, "_after_hs"}, 1'b1);
        cmd_valid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state.
        tick();
        tick();
        chk_idle_outputs("reset", 1'b0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_paddr", 32'(paddr), 32'd0);
        rstn = 1'b1;
        tick();
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        // name, wr, addr, wdata, ready_k, prdata, pslverr, hold, hold_valid
        xfer("wr_08",     1'b1, 10'h008, 8'h5A, 2,  8'hEE, 1'b0, 0, 1'b0);
        xfer("rd_10",     1'b0, 10'h010, 8'h00, 1,  8'h3C, 1'b0, 0, 1'b0);
        xfer("rd_04_err", 1'b0, 10'h004, 8'h00, 1,  8'h77, 1'b1, 0, 1'b0);
        xfer("timeout",   1'b0, 10'h014, 8'h00, 0,  8'h00, 1'b0, 0, 1'b0);
        xfer("ready_last",1'b0, 10'h018, 8'h00, TO, 8'hA5, 1'b0, 0, 1'b0);
        xfer("wr_err",    1'b1, 10'h3FF, 8'hC3, 3,  8'h99, 1'b1, 0, 1'b0);
        xfer("backpress", 1'b0, 10'h00C, 8'h00, 2,  8'h81, 1'b0, 5, 1'b1);

        // Reset in the third ACCESS cycle: no response may ever appear.
        chk("rst_mid_c0_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 10'h020;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid_access3_penable", 32'(penable), 32'd1);
        rstn   = 1'b0;
        pready = 1'b1;
        prdata = 8'hAA;
        tick();
        rstn   = 1'b1;
        pready = 1'b0;
        chk_idle_outputs("rst_mid_next", 1'b0);
        chk("rst_mid_paddr", 32'(paddr), 32'd0);
        chk("rst_mid_pwrite", 32'(pwrite), 32'd0);
        tick();
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("txn rst_mid addr=020 response=none");
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
